// File: rtl/param_electronic_clock.sv
// Digital clock with BCD time, a button-driven setting FSM, 12/24-hour display and a timed alarm.
// Buttons are active-low, synchronised and debounced; every output is registered.
module param_electronic_clock #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int ALARM_SECS      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time_button,
  input  logic       set_time_change_button,
  input  logic       set_time_add_button,
  input  logic       mode_12h,
  input  logic       alarm_en,
  output logic [3:0] hour_h_watch,
  output logic [3:0] hour_l_watch,
  output logic [3:0] minute_h_watch,
  output logic [3:0] minute_l_watch,
  output logic [3:0] second_h_watch,
  output logic [3:0] second_l_watch,
  output logic       pm,
  output logic       alarm_out,
  output logic [2:0] set_field,
  output logic       sec_tick
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } state_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] ACNT_MAX = AW'(ALARM_SECS - 1);

  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
    if (v >= 5'd20) return {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {4'd1, 4'(v - 5'd10)};
    else return {4'd0, v[3:0]};
  endfunction

  // Bit 0 = set, bit 1 = change, bit 2 = add.
  logic [2:0]    btn, sync1, sync2, stable, press;
  logic [DW-1:0] db_cnt [3];

  assign btn = {set_time_add_button, set_time_change_button, set_time_button};

  // A level is accepted after DEBOUNCE_CYCLES consecutive cycles differing from the stable one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state, state_d;
  logic [PW-1:0] pre_cnt, pre_d;
  logic [7:0]    hh, mm, ss, al_h, al_m;
  logic [7:0]    hh_d, mm_d, ss_d, al_h_d, al_m_d;
  logic [AW-1:0] al_cnt, acnt_d;
  logic          alarm_d, tick, running, show_al, pm_d;
  logic [7:0]    disp_h, disp_m, disp_s, disp_hh_d;
  logic [4:0]    hour_bin, hour12;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    pre_d   = pre_cnt;
    hh_d    = hh;
    mm_d    = mm;
    ss_d    = ss;
    al_h_d  = al_h;
    al_m_d  = al_m;
    alarm_d = alarm_out;
    acnt_d  = al_cnt;
    tick    = 1'b0;
    running = (state == RUN) || (state == SET_AH) || (state == SET_AM);

    if (running) begin
      if (pre_cnt == PRE_MAX) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_cnt + 1'b1;
      end
    end else begin
      pre_d = '0;
    end

    if (tick) begin
      ss_d = bcd_next(ss, 8'h59);
      if (ss == 8'h59) begin
        mm_d = bcd_next(mm, 8'h59);
        if (mm == 8'h59) hh_d = bcd_next(hh, 8'h23);
      end
    end

    // One event per cycle: set beats change beats add.
    if (press[0]) begin
      state_d = (state == RUN) ? SET_H : RUN;
    end else if (press[1]) begin
      case (state)
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        SET_AM:  state_d = SET_H;
        default: state_d = state;
      endcase
    end else if (press[2]) begin
      case (state)
        SET_H:   hh_d   = bcd_next(hh, 8'h23);
        SET_M:   mm_d   = bcd_next(mm, 8'h59);
        SET_S:   ss_d   = bcd_next(ss, 8'h59);
        SET_AH:  al_h_d = bcd_next(al_h, 8'h23);
        SET_AM:  al_m_d = bcd_next(al_m, 8'h59);
        default: ;
      endcase
    end

    if (state_d == RUN && state != RUN) pre_d = '0;

    if (tick && state == RUN && alarm_en && hh_d == al_h && mm_d == al_m && ss_d == 8'h00) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_out && tick) begin
      if (al_cnt == ACNT_MAX) alarm_d = 1'b0;
      else acnt_d = al_cnt + 1'b1;
    end
    if ((|press) || !alarm_en) alarm_d = 1'b0;

    // Display is built from next-state values so it lands on the same edge as the change.
    show_al  = (state_d == SET_AH) || (state_d == SET_AM);
    disp_h   = show_al ? al_h_d : hh_d;
    disp_m   = show_al ? al_m_d : mm_d;
    disp_s   = show_al ? 8'h00 : ss_d;
    hour_bin = {1'b0, disp_h[7:4]} * 5'd10 + {1'b0, disp_h[3:0]};
    hour12   = hour_bin;
    if (hour_bin == 5'd0) hour12 = 5'd12;
    else if (hour_bin > 5'd12) hour12 = hour_bin - 5'd12;
    pm_d      = mode_12h && (hour_bin >= 5'd12);
    disp_hh_d = mode_12h ? bin_to_bcd(hour12) : disp_h;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt   <= '0;
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      al_h      <= 8'h00;
      al_m      <= 8'h00;
      alarm_out <= 1'b0;
      al_cnt    <= '0;
      sec_tick  <= 1'b0;
      pm        <= 1'b0;
      {hour_h_watch, hour_l_watch}     <= 8'h00;
      {minute_h_watch, minute_l_watch} <= 8'h00;
      {second_h_watch, second_l_watch} <= 8'h00;
    end else begin
      pre_cnt   <= pre_d;
      hh        <= hh_d;
      mm        <= mm_d;
      ss        <= ss_d;
      al_h      <= al_h_d;
      al_m      <= al_m_d;
      alarm_out <= alarm_d;
      al_cnt    <= acnt_d;
      sec_tick  <= tick;
      pm        <= pm_d;
      {hour_h_watch, hour_l_watch}     <= disp_hh_d;
      {minute_h_watch, minute_l_watch} <= disp_m;
      {second_h_watch, second_l_watch} <= disp_s;
    end
  end

  assign set_field = state;

endmodule

// File: tb/tb_param_electronic_clock.sv
// Bench for param_electronic_clock: randomized setting and running scenarios checked
// against a seconds-of-day reference model, plus tick rate, debounce and alarm cases.
module tb_param_electronic_clock;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int ASECS  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic       mode_12h = 1'b0;
  logic       alarm_en = 1'b0;
  logic [3:0] hour_h_watch, hour_l_watch, minute_h_watch, minute_l_watch;
  logic [3:0] second_h_watch, second_l_watch;
  logic       pm, alarm_out, sec_tick;
  logic [2:0] set_field;

  int n_vec = 0;
  int n_err = 0;
  int t  = 0;  // model time, seconds of day
  int st = 0;  // model FSM state number
  int ah = 0;
  int am = 0;

  always #5 clk = ~clk;

  param_electronic_clock #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .ALARM_SECS(ASECS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_time_button(btn_n[0]),
    .set_time_change_button(btn_n[1]),
    .set_time_add_button(btn_n[2]),
    .mode_12h(mode_12h),
    .alarm_en(alarm_en),
    .hour_h_watch(hour_h_watch),
    .hour_l_watch(hour_l_watch),
    .minute_h_watch(minute_h_watch),
    .minute_l_watch(minute_l_watch),
    .second_h_watch(second_h_watch),
    .second_l_watch(second_l_watch),
    .pm(pm),
    .alarm_out(alarm_out),
    .set_field(set_field),
    .sec_tick(sec_tick)
  );

  function automatic logic [31:0] clock_word(input int secs, input logic m12);
    int h, m, s, dh;
    logic p;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    dh = h;
    p = 1'b0;
    if (m12) begin
      p = (h >= 12);
      dh = h % 12;
      if (dh == 0) dh = 12;
    end
    return {7'd0, p, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [31:0] dut_word();
    return {7'd0, pm, hour_h_watch, hour_l_watch, minute_h_watch, minute_l_watch,
            second_h_watch, second_l_watch};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int low);
    btn_n[b] = 1'b0;
    step(low);
    btn_n[b] = 1'b1;
    step(10);
  endtask

  // Full press plus the model's view of what that event does.
  task automatic press_ev(input int b);
    press(b, 6);
    case (b)
      0: st = (st == 0) ? 1 : 0;
      1: if (st != 0) st = (st == 5) ? 1 : st + 1;
      default: begin
        case (st)
          1: t = (t + 3600) % 86400;
          2: t = (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60 + t % 60;
          3: t = (t / 60) * 60 + (t % 60 + 1) % 60;
          4: ah = (ah + 1) % 24;
          5: am = (am + 1) % 60;
          default: ;
        endcase
      end
    endcase
    check("state", set_field, st);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn_n = 3'b111;
    step(3);
    check("rst_display", dut_word(), 32'd0);
    check("rst_state", set_field, 0);
    check("rst_alarm", alarm_out, 0);
    check("rst_tick", sec_tick, 0);
    @(negedge clk);
    rst = 1'b1;
    t = 0; st = 0; ah = 0; am = 0;
  endtask

  task automatic set_hms(input int h, input int m, input int s);
    for (int i = 0; i < h; i++) press_ev(2);
    press_ev(1);
    for (int i = 0; i < m; i++) press_ev(2);
    press_ev(1);
    for (int i = 0; i < s; i++) press_ev(2);
  endtask

  task automatic check_frozen(input string tag);
    for (int m12 = 0; m12 < 2; m12++) begin
      mode_12h = 1'(m12);
      step(1);
      check(tag, dut_word(), clock_word(t, mode_12h));
    end
  endtask

  // Leave set mode and follow the running clock one tick at a time, sampling mid-second.
  task automatic go_run(input int n);
    int b;
    btn_n[0] = 1'b0;
    for (int i = 0; i < 40 && set_field != 3'd0; i++) step(1);
    btn_n[0] = 1'b1;
    st = 0;
    check("run_entry", set_field, 0);
    step(5);
    for (int k = 0; k < n; k++) begin
      mode_12h = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k % 2 == 1 && $urandom_range(0, 1) == 1) begin
        b = $urandom_range(1, 2);
        btn_n[b] = 1'b0;
        step(6);
        btn_n[b] = 1'b1;
        step(4);
      end else begin
        step(10);
      end
      t = (t + 1) % 86400;
      check("run_time", dut_word(), clock_word(t, mode_12h));
      check("run_state", set_field, 0);
      check("alarm_idle", alarm_out, 0);
    end
  endtask

  task automatic alarm_setup();
    do_reset();
    mode_12h = 1'b0;
    alarm_en = 1'b0;
    press_ev(0);
    press_ev(1);
    press_ev(1);
    press_ev(1);
    check("alarm_view_h", dut_word(), clock_word(ah * 3600 + am * 60, 1'b0));
    press_ev(1);
    press_ev(2);
    press_ev(2);
    check("alarm_view_m", dut_word(), clock_word(ah * 3600 + am * 60, 1'b0));
    press_ev(0);
    alarm_en = 1'b1;
    for (int i = 0; i < 2000 && !alarm_out; i++) step(1);
    check("alarm_rise", alarm_out, 1);
    check("alarm_time", dut_word(), clock_word((ah * 60 + am) * 60, 1'b0));
  endtask

  initial begin
    int cnt, n;

    do_reset();
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (sec_tick) cnt++;
    end
    check("tick_count", cnt, 60);
    check("one_minute", dut_word(), clock_word(60, 1'b0));

    do_reset();
    press_ev(0);
    set_hms(3, 1, 0);
    check_frozen("frozen_0301");
    step(30);
    check("still_frozen", dut_word(), clock_word(t, mode_12h));
    go_run(4);

    do_reset();
    press_ev(0);
    set_hms(23, 59, 59);
    check_frozen("frozen_235959");
    go_run(2);

    do_reset();
    press_ev(0);
    set_hms(13, 5, 0);
    check_frozen("frozen_1305");
    go_run(3);

    do_reset();
    press_ev(0);
    press(2, 3);
    check_frozen("glitch_short");
    press_ev(2);
    check_frozen("glitch_long");

    for (int r = 0; r < 3; r++) begin
      do_reset();
      press_ev(0);
      set_hms($urandom_range(0, 30), $urandom_range(0, 65), $urandom_range(0, 65));
      check_frozen("frozen_rand");
      go_run($urandom_range(4, 10));
    end

    alarm_setup();
    n = 0;
    while (alarm_out && n < 100) begin
      step(1);
      n++;
    end
    check("alarm_len", n, ASECS * CLK_HZ);
    check("alarm_end_time", dut_word(), clock_word((ah * 60 + am) * 60 + ASECS, 1'b0));

    alarm_setup();
    step(11);
    btn_n[2] = 1'b0;
    for (int i = 0; i < 20 && alarm_out; i++) step(1);
    btn_n[2] = 1'b1;
    check("alarm_press_off", alarm_out, 0);
    check("alarm_press_time", dut_word(), clock_word((ah * 60 + am) * 60 + 1, 1'b0));
    step(10);

    alarm_setup();
    step(3);
    alarm_en = 1'b0;
    step(2);
    check("alarm_en_off", alarm_out, 0);

    alarm_setup();
    step(3);
    do_reset();
    alarm_en = 1'b1;
    step(20);
    check("post_rst_alarm", alarm_out, 0);
    check("post_rst_state", set_field, 0);
    alarm_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_electronic_clock.md
PARAM_ELECTRONIC_CLOCK -- requirements
Module: param_electronic_clock

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50_000_000: clk cycles per one-second tick.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default CLK_HZ/50: number of consecutive stable cycles needed to accept a button level.
REQ-003 SHALL provide parameter ALARM_SECS, default 30: alarm_out duration in seconds.
REQ-004 SHALL provide the following ports (name, direction, width, meaning), all synchronous to clk except rst:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous reset, active-low.
- set_time_button, in, 1: active-low; enters or leaves set mode.
- set_time_change_button, in, 1: active-low; selects the next field.
- set_time_add_button, in, 1: active-low; increments the selected field.
- mode_12h, in, 1: 1 = 12-hour display, 0 = 24-hour display.
- alarm_en, in, 1: alarm enable.
- hour_h_watch, hour_l_watch, minute_h_watch, minute_l_watch, second_h_watch, second_l_watch, out, 4 each: BCD display digits.
- pm, out, 1: PM indicator.
- alarm_out, out, 1: alarm active.
- set_field, out, 3: current FSM state encoding.
- sec_tick, out, 1: one-cycle pulse on each second tick.

Function
REQ-005 SHALL count a prescaler 0..CLK_HZ-1 and pulse sec_tick for one cycle when the count equals CLK_HZ-1, then wrap to 0.
REQ-006 SHALL hold time internally as 24-hour BCD; on a tick with time running, seconds SHALL increment, 59 SHALL wrap to 00 with carry into minutes, minutes SHALL behave the same with carry into hours, and 23:59:59 SHALL wrap to 00:00:00.
REQ-007 SHALL synchronise each button through two flops, then debounce it; a press event SHALL be a one-cycle pulse when the debounced level goes 1->0; a low level lasting fewer than DEBOUNCE_CYCLES cycles SHALL produce no event.
REQ-008 SHALL implement the FSM states RUN=0, SET_H=1, SET_M=2, SET_S=3, SET_AH=4, SET_AM=5, driven on set_field.
REQ-009 SHALL move RUN->SET_H on a set event, and any SET_* state ->RUN on a set event.
REQ-010 SHALL advance SET_H->SET_M->SET_S->SET_AH->SET_AM->SET_H on a change event; a change event in RUN SHALL be ignored.
REQ-011 SHALL, on an add event, increment the selected field modulo its range (hours 0-23, minutes/seconds 0-59) with no carry into other fields; an add event in RUN SHALL be ignored.
REQ-012 SHALL freeze time in SET_H/SET_M/SET_S, holding the prescaler at 0; time SHALL run in RUN, SET_AH and SET_AM; on entry to RUN the prescaler SHALL restart from 0.
REQ-013 SHALL resolve simultaneous events by priority set > change > add, with one event acted on per cycle.
REQ-014 SHALL, when a tick and a set event coincide in RUN, apply the tick before entering SET_H.
REQ-015 SHALL show the alarm hours and minutes on the display in SET_AH/SET_AM, with seconds digits 0,0; all other states SHALL show the time.
REQ-016 SHALL, with mode_12h=0, output hours 00-23 and pm=0.
REQ-017 SHALL, with mode_12h=1, map hour 0->12, 1-12 unchanged, 13-23->1-11, with pm=1 when the internal hour is 12 or above; mode_12h SHALL affect display only.
REQ-018 SHALL assert alarm_out on the tick where time becomes alarm_hh:alarm_mm:00, provided alarm_en=1 and the state is RUN.
REQ-019 SHALL deassert alarm_out after ALARM_SECS ticks, on any button press event, or when alarm_en=0, whichever comes first.
REQ-020 SHALL update all outputs from registers; display changes SHALL appear the cycle after the causing tick or event.

Reset
REQ-021 SHALL, on rst=0, asynchronously set time 00:00:00, alarm 00:00, state RUN, prescaler 0, debouncers to idle-high, and alarm_out=0, sec_tick=0, pm=0, set_field=0.
REQ-022 SHALL abort set mode or an active alarm on reset mid-operation, with no event generated on release.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4, ALARM_SECS=3)
REQ-023 SHALL pass: reset release then 600 clk -> 60 sec_tick pulses, display 00:01:00.
REQ-024 SHALL pass: set 23:59:59 via the FSM, return to RUN, wait 1 tick -> 00:00:00 with pm=0.
REQ-025 SHALL pass: time 13:05 with mode_12h=1 -> hour digits 0,1 and pm=1; time 00:xx -> 1,2 and pm=0.
REQ-026 SHALL pass: set press, add x3, change, add, set -> display frozen at 03:01:00 during setting, then running from 03:01:00.
REQ-027 SHALL pass: 3-cycle low glitch on set_time_add_button in SET_H -> hour unchanged; 6-cycle low -> +1.
REQ-028 SHALL pass: alarm 00:02, alarm_en=1 -> alarm_out rises at 00:02:00 and falls after 3 ticks; a repeat run with an add press at 00:02:01 -> alarm_out falls 1 cycle after the event.
